// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the irq_source interrupt generator:
//   - register addresses of the memory-mapped register file
//   - CTRL register field offsets
//   - per-channel FSM state encoding
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam logic [1:0] ADDR_PERIOD0 = 2'd0;
    localparam logic [1:0] ADDR_PERIOD1 = 2'd1;
    localparam logic [1:0] ADDR_PERIOD2 = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int TEN_LSB  = 0;   // timer enables (R/W)
    localparam int BEN_LSB  = 8;   // button enables (R/W)
    localparam int CLR_LSB  = 16;  // pending clear (W1C, reads 0)
    localparam int PEND_LSB = 24;  // pending counts, 2 bits per channel (RO)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } ch_state_t;

endpackage

// File: rtl/irq_channel.sv
// -----------------------------------------------------------------------------
// irq_channel
// One interrupt line: interval timer, button synchroniser + rising-edge
// detector, pending event counter and the pulse-shaping FSM.
//
// Optional feature: IRQ_SOURCE_COALESCE_EN - when defined, pending is a single
// flag so any burst of events before a pulse starts yields one pulse.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   period_wr    load period and restart the counter from period_din
//   period_din   new timer period
//   tmr_en       timer enable
//   btn_en       button enable
//   pend_clr     clear pending (wins over a same-cycle event)
//   btn          asynchronous push-button input
//   period       current period (readback)
//   pend_cnt     pending event count (readback)
//   ir           registered interrupt request line
//
// FSM states:
//   state | meaning
//   IDLE  | line low, waiting for a pending event
//   PULSE | line high for PULSE_LEN cycles
//   GAP   | line low for GAP_LEN cycles before the next pulse may start
// -----------------------------------------------------------------------------
module irq_channel
    import irq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             period_wr,
    input  logic [CNT_W-1:0] period_din,
    input  logic             tmr_en,
    input  logic             btn_en,
    input  logic             pend_clr,
    input  logic             btn,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       pend_cnt,
    output logic             ir
);

    localparam int PH_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    // ---------------- interval timer ----------------
    logic [CNT_W-1:0] cnt;
    logic             tmr_run;
    logic             tmr_evt;

    assign tmr_run = tmr_en && (period != '0);
    assign tmr_evt = tmr_run && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
            cnt    <= '0;
        end else if (period_wr) begin
            period <= period_din;
            cnt    <= period_din;
        end else if (tmr_evt) begin
            cnt <= period;
        end else if (tmr_run) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // ---------------- button synchroniser + edge detect ----------------
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_prev;
    logic                   btn_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            btn_prev <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], btn};
            btn_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign btn_evt = btn_en && sync[SYNC_STAGES-1] && !btn_prev;

    // Timer and button events in the same cycle merge into one.
    logic evt;
    assign evt = tmr_evt || btn_evt;

    // ---------------- pending ----------------
    logic start;
    logic pend_nz;

`ifdef IRQ_SOURCE_COALESCE_EN
    logic pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (pend_clr) begin
            pend <= 1'b0;
        end else if (evt) begin
            pend <= 1'b1;
        end else if (start) begin
            pend <= 1'b0;
        end
    end

    assign pend_nz  = pend;
    assign pend_cnt = {1'b0, pend};
`else
    logic [1:0] pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 2'd0;
        end else if (pend_clr) begin
            pend <= 2'd0;
        end else if (evt && !start) begin
            if (pend != 2'd3) begin
                pend <= pend + 2'd1;
            end
        end else if (!evt && start) begin
            pend <= pend - 2'd1;
        end
    end

    assign pend_nz  = (pend != 2'd0);
    assign pend_cnt = pend;
`endif

    // ---------------- pulse FSM ----------------
    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_nxt;
    logic             ir_nxt;

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_nz) begin
                    state_nxt = PULSE;
                    ph_nxt    = PH_W'(PULSE_LEN - 1);
                    start     = 1'b1;
                end
            end
            PULSE: begin
                if (ph == '0) begin
                    state_nxt = GAP;
                    ph_nxt    = PH_W'(GAP_LEN - 1);
                end else begin
                    ph_nxt = ph - PH_W'(1);
                end
            end
            GAP: begin
                if (ph == '0) begin
                    state_nxt = IDLE;
                end else begin
                    ph_nxt = ph - PH_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // ir is registered but must already be high in the first PULSE cycle.
        ir_nxt = (state_nxt == PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ph    <= '0;
            ir    <= 1'b0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            ir    <= ir_nxt;
        end
    end

endmodule

// File: rtl/irq_source.sv
// -----------------------------------------------------------------------------
// irq_source
// Peripheral interrupt generator feeding the CP0 edge-sampled ir lines.
// Holds the bus register decode, the CTRL enables and the readback mux; each
// line is produced by one irq_channel instance.
//
// Optional feature: IRQ_SOURCE_COALESCE_EN (see irq_channel) - pending becomes
// a 1-bit flag and the upper bit of each CTRL pending field reads 0.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   we           bus write strobe
//   addr         register select (0..2 PERIOD[ch], 3 CTRL)
//   din          write data
//   dout         read data, combinational from addr
//   btn          asynchronous push buttons, one per channel
//   ir           registered interrupt request lines
// -----------------------------------------------------------------------------
module irq_source
    import irq_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int CNT_W       = 32,
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [1:0]     addr,
    input  logic [31:0]    din,
    output logic [31:0]    dout,
    input  logic [NCH-1:0] btn,
    output logic [NCH-1:0] ir
);

    logic [NCH-1:0]   tmr_en;
    logic [NCH-1:0]   btn_en;
    logic [NCH-1:0]   pend_clr;
    logic [NCH-1:0]   period_wr;
    logic [CNT_W-1:0] period   [NCH];
    logic [1:0]       pend_cnt [NCH];
    logic             ctrl_wr;
    logic             din_unused;

    // Reserved CTRL bits and din bits above CNT_W are ignored on writes.
    assign din_unused = ^din;

    assign ctrl_wr  = we && (addr == ADDR_CTRL);
    assign pend_clr = ctrl_wr ? din[CLR_LSB +: NCH] : '0;

    // The 2-bit address map holds three PERIOD registers.
    always_comb begin
        period_wr = '0;
        if (we) begin
            case (addr)
                ADDR_PERIOD0: period_wr[0] = 1'b1;
                ADDR_PERIOD1: period_wr[1] = 1'b1;
                ADDR_PERIOD2: period_wr[2] = 1'b1;
                default:      period_wr    = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_en <= '0;
            btn_en <= '0;
        end else if (ctrl_wr) begin
            tmr_en <= din[TEN_LSB +: NCH];
            btn_en <= din[BEN_LSB +: NCH];
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_PERIOD0: dout[CNT_W-1:0] = period[0];
            ADDR_PERIOD1: dout[CNT_W-1:0] = period[1];
            ADDR_PERIOD2: dout[CNT_W-1:0] = period[2];
            ADDR_CTRL: begin
                dout[TEN_LSB +: NCH] = tmr_en;
                dout[BEN_LSB +: NCH] = btn_en;
                for (int i = 0; i < NCH; i++) begin
                    dout[PEND_LSB + 2*i +: 2] = pend_cnt[i];
                end
            end
            default: dout = '0;
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        irq_channel #(
            .CNT_W       (CNT_W),
            .PULSE_LEN   (PULSE_LEN),
            .GAP_LEN     (GAP_LEN),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .period_wr  (period_wr[i]),
            .period_din (din[CNT_W-1:0]),
            .tmr_en     (tmr_en[i]),
            .btn_en     (btn_en[i]),
            .pend_clr   (pend_clr[i]),
            .btn        (btn[i]),
            .period     (period[i]),
            .pend_cnt   (pend_cnt[i]),
            .ir         (ir[i])
        );
    end

endmodule

// File: tb/tb_irq_source.sv
// -----------------------------------------------------------------------------
// tb_irq_source
// Self-checking bench for irq_source: directed scenarios followed by random
// bus/button traffic, all compared cycle by cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_irq_source;

    localparam int NCH         = 3;
    localparam int PULSE_LEN   = 4;
    localparam int GAP_LEN     = 2;
    localparam int SYNC_STAGES = 2;
`ifdef IRQ_SOURCE_COALESCE_EN
    localparam int PEND_MAX = 1;
`else
    localparam int PEND_MAX = 3;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic [31:0] din   = 32'd0;
    logic [31:0] dout;
    logic [2:0]  btn   = 3'd0;
    logic [2:0]  ir;

    irq_source dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .btn   (btn),
        .ir    (ir)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: integer timers, pending counts and a
    // "cycles remaining in pulse+gap" count per channel.
    int unsigned        m_per  [NCH];
    int unsigned        m_cnt  [NCH];
    int                 m_pend [NCH];
    int                 m_rem  [NCH];
    bit [NCH-1:0]       m_ten;
    bit [NCH-1:0]       m_ben;
    bit [NCH-1:0]       m_ir;
    bit [SYNC_STAGES:0] m_hist [NCH];   // bit j = btn seen j+1 cycles ago

    int          rises [NCH];
    logic [2:0]  prev_ir = 3'd0;
    logic [31:0] last_dout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i]  = 0;
            m_cnt[i]  = 0;
            m_pend[i] = 0;
            m_rem[i]  = 0;
            m_hist[i] = '0;
        end
        m_ten = '0;
        m_ben = '0;
        m_ir  = '0;
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        logic [31:0] r = '0;
        if (a < 2'd3) begin
            r = m_per[a];
        end else begin
            r[2:0]  = m_ten;
            r[10:8] = m_ben;
            for (int i = 0; i < NCH; i++) r[24 + 2*i +: 2] = 2'(m_pend[i]);
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs of the ending cycle.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit ev;
            bit start;
            bit clr;
            ev    = (m_ten[i] && m_per[i] != 0 && m_cnt[i] == 1) ||
                    (m_ben[i] && m_hist[i][SYNC_STAGES-1] && !m_hist[i][SYNC_STAGES]);
            start = (m_rem[i] == 0) && (m_pend[i] > 0);
            clr   = we && (addr == 2'd3) && din[16+i];
            if (clr) begin
                m_pend[i] = 0;
            end else begin
`ifdef IRQ_SOURCE_COALESCE_EN
                if (ev) m_pend[i] = 1;
                else if (start) m_pend[i] = 0;
`else
                m_pend[i] = m_pend[i] + int'(ev) - int'(start);
                if (m_pend[i] > PEND_MAX) m_pend[i] = PEND_MAX;
`endif
            end
            if (m_rem[i] > 0) m_rem[i]--;
            else if (start) m_rem[i] = PULSE_LEN + GAP_LEN;
            m_ir[i] = (m_rem[i] > GAP_LEN);
            if (we && addr == 2'(i)) begin
                m_per[i] = din;
                m_cnt[i] = din;
            end else if (m_ten[i] && m_per[i] != 0) begin
                m_cnt[i] = (m_cnt[i] == 1) ? m_per[i] : m_cnt[i] - 1;
            end
            m_hist[i] = {m_hist[i][SYNC_STAGES-1:0], btn[i]};
        end
        if (we && addr == 2'd3) begin
            m_ten = din[2:0];
            m_ben = din[10:8];
        end
    endtask

    // Called at a falling edge: drive one cycle, check readback and ir.
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [2:0] b);
        we   = w;
        addr = a;
        din  = d;
        btn  = b;
        #1;
        last_dout = dout;
        check_val("dout", dout, model_dout(a));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("ir", {29'd0, ir}, {29'd0, m_ir});
        for (int i = 0; i < NCH; i++) if (ir[i] && !prev_ir[i]) rises[i]++;
        prev_ir = ir;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd3, 32'd0, 3'd0);
    endtask

    int k;
    int r0;
    logic [2:0] rb;

    initial begin
        model_reset();
        for (int i = 0; i < NCH; i++) rises[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state of all registers
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 2'(a), 32'd0, 3'd0);
            check_val("reset_dout", last_dout, 32'd0);
        end

        // timer ch0, period 5
        step(1'b1, 2'd0, 32'd5, 3'd0);
        step(1'b1, 2'd3, 32'h1, 3'd0);
        k = -1;
        for (int n = 1; n <= 20 && k < 0; n++) begin
            step(1'b0, 2'd3, 32'd0, 3'd0);
            if (ir[0]) k = n;
        end
        check_val("t0_first_rise", k, 6);
        idle(20);
        step(1'b1, 2'd3, 32'd0, 3'd0);
        step(1'b1, 2'd0, 32'd0, 3'd0);
        idle(30);

        // button ch2: one pulse, SYNC_STAGES+2 cycles after the press
        step(1'b1, 2'd3, 32'h400, 3'd0);
        r0 = rises[2];
        k  = -1;
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 2'd3, 32'd0, (n < 10) ? 3'b100 : 3'b000);
            if (k < 0 && ir[2]) k = n;
        end
        check_val("b2_latency", k, SYNC_STAGES + 1);
        check_val("b2_rises", rises[2] - r0, 1);
        step(1'b1, 2'd3, 32'd0, 3'd0);
        r0 = rises[2];
        for (int n = 0; n < 30; n++) step(1'b0, 2'd3, 32'd0, (n < 10) ? 3'b100 : 3'b000);
        check_val("b2_disabled", rises[2] - r0, 0);

        // ch1 saturation: period 1 gives an event every enabled cycle
        step(1'b1, 2'd1, 32'd1, 3'd0);
        step(1'b1, 2'd3, 32'h2, 3'd0);
        repeat (5) step(1'b0, 2'd3, 32'd0, 3'd0);
        step(1'b1, 2'd3, 32'd0, 3'd0);
        step(1'b0, 2'd3, 32'd0, 3'd0);
        check_val("pend_sat", last_dout[27:26], PEND_MAX);

        // W1C clear during a pulse: pulse completes, nothing more
        for (int n = 0; n < 20 && !ir[1]; n++) step(1'b0, 2'd3, 32'd0, 3'd0);
        check_val("clr_setup_ir1", ir[1], 1);
        step(1'b1, 2'd3, 32'h2_0000, 3'd0);
        r0 = rises[1];
        idle(30);
        step(1'b0, 2'd3, 32'd0, 3'd0);
        check_val("clr_pend", last_dout[27:26], 0);
        check_val("clr_rises", rises[1] - r0, 0);

        // timer + button on ch0 in the same cycle merge into one event
        step(1'b1, 2'd0, 32'd4, 3'd0);
        step(1'b1, 2'd3, 32'h101, 3'd0);
        step(1'b0, 2'd3, 32'd0, 3'd0);
        r0 = rises[0];
        repeat (3) step(1'b0, 2'd3, 32'd0, 3'b001);
        step(1'b0, 2'd3, 32'd0, 3'b001);
        check_val("merge_pend", last_dout[25:24], 1);
        step(1'b1, 2'd3, 32'd0, 3'd0);
        step(1'b1, 2'd0, 32'd0, 3'd0);
        idle(20);
        check_val("merge_rises", rises[0] - r0, 1);

        // asynchronous reset in the middle of an ir[1] pulse
        step(1'b1, 2'd3, 32'h200, 3'd0);
        for (int n = 0; n < 10 && !ir[1]; n++) step(1'b0, 2'd3, 32'd0, 3'b010);
        check_val("rst_setup_ir1", ir[1], 1);
        #2 rst_n = 1'b0;
        #1 check_val("rst_async_ir", {29'd0, ir}, 32'd0);
        model_reset();
        @(negedge clk);
        btn     = 3'd0;
        rst_n   = 1'b1;
        prev_ir = 3'd0;
        step(1'b0, 2'd3, 32'd0, 3'd0);
        check_val("rst_ctrl", last_dout, 32'd0);
        step(1'b0, 2'd1, 32'd0, 3'd0);
        check_val("rst_period1", last_dout, 32'd0);

        // random traffic
        rb = 3'd0;
        for (int n = 0; n < 800; n++) begin
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 7) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd3) begin
                d = $urandom;
                if ($urandom_range(0, 3) != 0) d[18:16] = 3'd0;
            end else begin
                d = $urandom_range(0, 12);
            end
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
            step(w, a, d, rb);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
